// File: rtl/pll_drp_reconfig_ctrl_if.sv
// pll_drp_reconfig_ctrl_if: request handshake and DRP bus between the reconfig sequencer and its neighbours
interface pll_drp_reconfig_ctrl_if;
    logic        cfg_req;
    logic [6:0]  cfg_div;
    logic [6:0]  cfg_mult;
    logic        cfg_ack;
    logic        cfg_err;
    logic        busy;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        input  cfg_req, cfg_div, cfg_mult, drp_do, drp_drdy,
        output cfg_ack, cfg_err, busy, drp_daddr, drp_den, drp_dwe, drp_di
    );

    modport slave (
        output cfg_req, cfg_div, cfg_mult, drp_do, drp_drdy,
        input  cfg_ack, cfg_err, busy, drp_daddr, drp_den, drp_dwe, drp_di
    );
endinterface

// File: rtl/pll_drp_reconfig_ctrl.sv
// pll_drp_reconfig_ctrl: PLL divider reconfiguration over DRP (read-modify-write) and core reset owner
module pll_drp_reconfig_ctrl #(
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RST_STRETCH  = 16
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    pll_drp_reconfig_ctrl_if.master bus,
    output logic                    pll_rst,
    input  logic                    pll_locked,
    output logic                    rst_core_n
);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam int MW = $clog2(RST_STRETCH + 1);

    typedef enum logic [2:0] {IDLE, PRST, RD, RD_W, WR, WR_W, REL, LOCK_W} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    entry_q, entry_d;
    logic [6:0]    div_q, div_d, mult_q, mult_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_flag_q, err_flag_d;
    logic          armed_q, armed_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic          pll_rst_q, pll_rst_d;
    logic          den_q, den_d, dwe_q, dwe_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [15:0]   di_q, di_d;
    logic          lock_meta_q, lock_s_q;
    logic [MW-1:0] mon_q, mon_d;
    logic          mon_clr;
    logic          rst_core_n_q, rst_core_n_d;

    logic          legal, hold_done, drp_to, lock_to;
    logic [6:0]    n, addr;
    logic [5:0]    h, l;
    logic [15:0]   keep, new_val;

    assign legal = bus.cfg_div != 7'd0 && bus.cfg_div <= 7'd64 && bus.cfg_mult >= 7'd2 && bus.cfg_mult <= 7'd64;
    assign hold_done = cnt_q >= CW'(RST_HOLD - 1);
    assign drp_to = cnt_q >= CW'(DRDY_TIMEOUT);
    assign lock_to = cnt_q >= CW'(LOCK_TIMEOUT - 1);

    // Entry decode: odd entries are Reg2 (edge/no-count), even are Reg1 (high/low time); divide 1 bypasses the counter with edge cleared
    assign n = entry_d[1] ? mult_q : div_q;
    assign h = n[6:1];
    assign l = n[5:0] - h;
    assign keep = entry_d[0] ? 16'hFF00 : 16'h1000;
    assign new_val = entry_d[0] ? {8'h00, n[0] & (n != 7'd1), n == 7'd1, 6'h00} : {4'h0, h, l};
    assign addr = (entry_d[1] ? 7'h14 : 7'h08) | {6'd0, entry_d[0]};

    // Sequencer state and all registered outputs
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            entry_q    <= '0;
            div_q      <= '0;
            mult_q     <= '0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            armed_q    <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            pll_rst_q  <= 1'b1;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            entry_q    <= entry_d;
            div_q      <= div_d;
            mult_q     <= mult_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            armed_q    <= armed_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            pll_rst_q  <= pll_rst_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
        end
    end

    // Next-state logic, argument latch, DRP read capture and completion pulses
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        entry_d    = entry_q;
        div_d      = div_q;
        mult_d     = mult_q;
        rdata_d    = rdata_q;
        err_flag_d = err_flag_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.cfg_req && armed_q) begin
                    if (legal) begin
                        state_d    = PRST;
                        div_d      = bus.cfg_div;
                        mult_d     = bus.cfg_mult;
                        err_flag_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRST: if (hold_done) begin
                state_d = RD;
                entry_d = 2'd0;
                cnt_d   = '0;
            end
            RD: begin
                state_d = RD_W;
                cnt_d   = '0;
            end
            RD_W: if (bus.drp_drdy) begin
                rdata_d = bus.drp_do;
                state_d = WR;
                cnt_d   = '0;
            end else if (drp_to) begin
                err_flag_d = 1'b1;
                state_d    = REL;
            end
            WR: begin
                state_d = WR_W;
                cnt_d   = '0;
            end
            WR_W: if (bus.drp_drdy) begin
                entry_d = entry_q + 2'd1;
                state_d = entry_q == 2'd3 ? REL : RD;
                cnt_d   = '0;
            end else if (drp_to) begin
                err_flag_d = 1'b1;
                state_d    = REL;
            end
            REL: begin
                state_d = LOCK_W;
                cnt_d   = '0;
            end
            LOCK_W: if (lock_s_q) begin
                state_d = IDLE;
                ack_d   = !err_flag_q;
                err_d   = err_flag_q;
            end else if (lock_to) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        armed_d = !bus.cfg_req || (armed_q && !(ack_d || err_d));
    end

    // Outputs registered from the next state so they align with the state they belong to
    always_comb begin
        pll_rst_d = state_d inside {PRST, RD, RD_W, WR, WR_W};
        den_d     = state_d == RD || state_d == WR;
        dwe_d     = state_d == WR;
        daddr_d   = den_d ? addr : daddr_q;
        di_d      = dwe_d ? (rdata_d & keep) | (new_val & ~keep) : di_q;
    end

    // Lock synchroniser, settle counter and core reset register
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            mon_q        <= '0;
            rst_core_n_q <= 1'b0;
        end else begin
            lock_meta_q  <= pll_locked;
            lock_s_q     <= lock_meta_q;
            mon_q        <= mon_d;
            rst_core_n_q <= rst_core_n_d;
        end
    end

    // Settle counter restarts on any lock loss, PLL reset or sequencer activity
    always_comb begin
        mon_clr      = !lock_s_q || pll_rst_q || state_q != IDLE;
        mon_d        = mon_clr ? '0 : (mon_q == MW'(RST_STRETCH) ? mon_q : mon_q + MW'(1));
        rst_core_n_d = mon_d == MW'(RST_STRETCH);
    end

    assign pll_rst       = pll_rst_q;
    assign rst_core_n    = rst_core_n_q;
    assign bus.cfg_ack   = ack_q;
    assign bus.cfg_err   = err_q;
    assign bus.busy      = state_q != IDLE || pll_rst_q;
    assign bus.drp_den   = den_q;
    assign bus.drp_dwe   = dwe_q;
    assign bus.drp_daddr = daddr_q;
    assign bus.drp_di    = di_q;
endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// tb_pll_drp_reconfig_ctrl: directed bench with DRP/PLL models for the reconfig sequencer
module tb_pll_drp_reconfig_ctrl;
    logic        clk_sys = 1'b0;
    logic        rst_sys = 1'b1;
    logic        pll_rst, rst_core_n, pll_locked;
    logic        lock_m = 1'b0, lock_force = 1'b0, lock_auto = 1'b0, lock_dead = 1'b0;
    logic        drp_dead = 1'b0, drdy_m = 1'b0;
    logic [15:0] do_m = 16'h0000;
    logic [6:0]  pend_addr = 7'd0;
    logic [6:0]  wr_addr [0:63];
    logic [15:0] wr_data [0:63];
    int          lock_cnt = 20, pend = 0;
    int          wr_n = 0, den_n = 0, ack_n = 0, err_n = 0, wr_norst = 0;
    int          checks = 0, errors = 0;

    pll_drp_reconfig_ctrl_if bus();

    assign bus.drp_drdy = drdy_m;
    assign bus.drp_do   = do_m;
    assign pll_locked   = lock_auto ? lock_m : lock_force;

    pll_drp_reconfig_ctrl dut (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .bus        (bus),
        .pll_rst    (pll_rst),
        .pll_locked (pll_locked),
        .rst_core_n (rst_core_n)
    );

    always #5 clk_sys = ~clk_sys;

    // DRP slave (drdy 3 cycles after den), write logger, pulse counters and PLL lock model
    always @(negedge clk_sys) begin
        drdy_m = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && !drp_dead) begin
                drdy_m = 1'b1;
                do_m   = pend_addr[0] ? 16'hAB55 : 16'hFFFF;
            end
        end
        if (bus.drp_den) begin
            pend      = 3;
            pend_addr = bus.drp_daddr;
            den_n++;
            if (bus.drp_dwe) begin
                wr_addr[wr_n] = bus.drp_daddr;
                wr_data[wr_n] = bus.drp_di;
                if (!pll_rst) wr_norst++;
                wr_n++;
            end
        end
        if (bus.cfg_ack) ack_n++;
        if (bus.cfg_err) err_n++;
        if (!lock_auto) begin
            lock_m   = lock_force;
            lock_cnt = 20;
        end else if (pll_rst) begin
            lock_cnt = 0;
            lock_m   = 1'b0;
        end else if (lock_dead) begin
            lock_m = 1'b0;
        end else if (lock_cnt < 20) begin
            lock_cnt++;
        end else begin
            lock_m = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [6:0] d, input logic [6:0] m, input int hold, input int limit,
                       output logic ack, output logic err, output int cyc);
        bus.cfg_div  = d;
        bus.cfg_mult = m;
        bus.cfg_req  = 1'b1;
        ack = 1'b0;
        err = 1'b0;
        cyc = 0;
        while (!ack && !err && cyc < limit) begin
            @(negedge clk_sys);
            cyc++;
            ack = bus.cfg_ack;
            err = bus.cfg_err;
        end
        repeat (hold) @(negedge clk_sys);
        bus.cfg_req = 1'b0;
    endtask

    task automatic wait_core(input string tag);
        int i = 0;
        while (!rst_core_n && i < 200) begin
            @(negedge clk_sys);
            i++;
        end
        chk(tag, rst_core_n, 1);
    endtask

    initial begin
        logic ack, err;
        int   cyc, b, d0, a0, e0, n0, k;
        bus.cfg_req  = 1'b0;
        bus.cfg_div  = 7'd0;
        bus.cfg_mult = 7'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ctl", {pll_rst, bus.busy, rst_core_n, bus.drp_den, bus.drp_dwe, bus.cfg_ack, bus.cfg_err}, 7'b1100000);
        chk("rst_bus", {bus.drp_daddr, bus.drp_di}, 0);
        rst_sys = 1'b0;
        @(negedge clk_sys);
        chk("boot_idle", {pll_rst, bus.busy}, 0);

        // T1 boot: lock arrives, core reset stretched by sync + 16
        repeat (9) @(negedge clk_sys);
        lock_force = 1'b1;
        k = 0;
        while (!rst_core_n && k < 100) begin
            @(negedge clk_sys);
            k++;
        end
        chk("t1_stretch", k, 18);
        chk("t1_no_drp", den_n, 0);
        lock_auto = 1'b1;

        // T2 div=20 mult=5, req held 3 cycles past ack
        b = wr_n; d0 = den_n; a0 = ack_n; e0 = err_n; n0 = wr_norst;
        req(7'd20, 7'd5, 3, 500, ack, err, cyc);
        chk("t2_result", {ack, err}, 2'b10);
        chk("t2_noreacc", bus.busy, 0);
        chk("t2_nwr", wr_n - b, 4);
        chk("t2_w0", {wr_addr[b], wr_data[b]}, {7'h08, 16'h128A});
        chk("t2_w1", {wr_addr[b+1], wr_data[b+1]}, {7'h09, 16'hAB00});
        chk("t2_w2", {wr_addr[b+2], wr_data[b+2]}, {7'h14, 16'h1083});
        chk("t2_w3", {wr_addr[b+3], wr_data[b+3]}, {7'h15, 16'hAB80});
        chk("t2_rst_hi", wr_norst - n0, 0);
        chk("t2_den", den_n - d0, 8);
        chk("t2_acks", ack_n - a0, 1);
        chk("t2_errs", err_n - e0, 0);
        wait_core("t2_core");

        // T3 div=1
        b = wr_n;
        req(7'd1, 7'd5, 0, 500, ack, err, cyc);
        chk("t3_result", {ack, err}, 2'b10);
        chk("t3_w0", {wr_addr[b], wr_data[b]}, {7'h08, 16'h1001});
        chk("t3_w1", {wr_addr[b+1], wr_data[b+1]}, {7'h09, 16'hAB40});
        wait_core("t3_core");

        // T4 illegal div=0
        d0 = den_n; e0 = err_n;
        req(7'd0, 7'd5, 0, 10, ack, err, cyc);
        chk("t4_result", {ack, err}, 2'b01);
        chk("t4_lat", cyc, 1);
        repeat (2) @(negedge clk_sys);
        chk("t4_noden", den_n - d0, 0);
        chk("t4_errs", err_n - e0, 1);
        chk("t4_pins", {pll_rst, rst_core_n, bus.busy}, 3'b010);
        req(7'd20, 7'd65, 0, 10, ack, err, cyc);
        chk("t4_mult65", {ack, err, bus.busy}, 3'b010);

        // T5 drdy never returns on the first read
        repeat (2) @(negedge clk_sys);
        drp_dead = 1'b1;
        d0 = den_n; b = wr_n;
        repeat (2) @(negedge clk_sys);
        req(7'd20, 7'd5, 0, 1000, ack, err, cyc);
        chk("t5_result", {ack, err}, 2'b01);
        chk("t5_drdy_to", cyc > 70 && cyc < 120, 1);
        chk("t5_one_den", den_n - d0, 1);
        chk("t5_no_wr", wr_n - b, 0);
        drp_dead = 1'b0;
        wait_core("t5_core");

        // T5 lock never returns
        lock_dead = 1'b1;
        b = wr_n;
        repeat (2) @(negedge clk_sys);
        req(7'd20, 7'd5, 0, 70000, ack, err, cyc);
        chk("t5_lock_result", {ack, err}, 2'b01);
        chk("t5_lock_to", cyc > 65536 && cyc < 65700, 1);
        chk("t5_lock_wr", wr_n - b, 4);
        lock_dead = 1'b0;
        wait_core("t5_lock_core");

        // T6 async reset during entry 2 WR_W
        b = wr_n;
        bus.cfg_div  = 7'd20;
        bus.cfg_mult = 7'd5;
        bus.cfg_req  = 1'b1;
        k = 0;
        while (!(bus.drp_den && bus.drp_dwe && bus.drp_daddr == 7'h14) && k < 300) begin
            @(negedge clk_sys);
            k++;
        end
        chk("t6_found", k < 300, 1);
        @(negedge clk_sys);
        #2 rst_sys = 1'b1;
        #1 chk("t6_rst", {bus.drp_den, bus.drp_dwe, pll_rst, bus.busy, rst_core_n}, 5'b00110);
        bus.cfg_req = 1'b0;
        @(negedge clk_sys);
        rst_sys = 1'b0;
        repeat (40) @(negedge clk_sys);
        chk("t6_nowr", wr_n - b, 3);
        chk("t6_idle", {bus.busy, pll_rst}, 0);
        wait_core("t6_core");

        // T6 lock loss in IDLE
        lock_auto  = 1'b0;
        lock_force = 1'b0;
        k = 0;
        while (rst_core_n && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        chk("t6_loss", k, 3);
        chk("t6_fsm", {bus.busy, pll_rst, bus.drp_den}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
